cpu_run_ctrl: RTL and testbench

Run-control sequencer for the 8-bit microprocessor core: it produces the single clock-enable `cpu_en` that gates every state update in the core (PC, register file, data memory). It supports free-run, single-step, halt-button stop, halt-instruction stop and one PC breakpoint. It watches the core's `pc` and the IMEM `instruction` bus and counts executed instructions. It sits between the board buttons (already debounced and pulse-converted) and the core.

---
 rtl/cpu_run_ctrl.sv | 120 ++++++++++++
 tb/tb_cpu_run_ctrl.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_run_ctrl.sv
// Run-control sequencer for the 8-bit core: produces the core clock-enable for free-run,
// single-step, halt-button, halt-instruction and PC-breakpoint stops, and counts retired cycles.
module cpu_run_ctrl #(
  parameter logic [7:0] HALT_INST = 8'hFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run_btn,
  input  logic        step_btn,
  input  logic        halt_btn,
  input  logic        clr_cnt,
  input  logic        bp_en,
  input  logic [7:0]  bp_addr,
  input  logic [7:0]  pc,
  input  logic [7:0]  instruction,
  output logic        cpu_en,
  output logic [1:0]  state,
  output logic [1:0]  stop_cause,
  output logic        bp_hit,
  output logic [15:0] retired
);

  typedef enum logic [1:0] {
    StHalt  = 2'd0,
    StRun   = 2'd1,
    StStep  = 2'd2,
    StBreak = 2'd3
  } state_e;

  localparam logic [1:0] CauseNone = 2'd0;
  localparam logic [1:0] CauseBtn  = 2'd1;
  localparam logic [1:0] CauseInst = 2'd2;
  localparam logic [1:0] CauseBp   = 2'd3;

  state_e      state_q, state_d;
  logic [1:0]  cause_q, cause_d;
  logic        skip_q, skip_d;
  logic [15:0] retired_q, retired_d;

  logic is_halt_inst, bp_match, stop;

  assign is_halt_inst = (instruction == HALT_INST);
  // skip suppresses the breakpoint once so a resume can execute the breakpointed instruction
  assign bp_match     = bp_en && (pc == bp_addr) && !skip_q;
  assign stop         = halt_btn || is_halt_inst || bp_match;

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    skip_d  = skip_q;
    cpu_en  = 1'b0;
    unique case (state_q)
      StHalt, StBreak: begin
        if (step_btn) begin
          state_d = StStep;
          skip_d  = 1'b1;
        end else if (run_btn) begin
          state_d = StRun;
          skip_d  = 1'b1;
        end
      end
      StRun: begin
        if (stop) begin
          if (halt_btn) begin
            cause_d = CauseBtn;
            state_d = StHalt;
          end else if (is_halt_inst) begin
            cause_d = CauseInst;
            state_d = StHalt;
          end else begin
            cause_d = CauseBp;
            state_d = StBreak;
          end
        end else begin
          cpu_en = 1'b1;
          skip_d = 1'b0;
        end
      end
      StStep: begin
        state_d = StHalt;
        skip_d  = 1'b0;
        if (is_halt_inst) begin
          cause_d = CauseInst;
        end else begin
          cpu_en = 1'b1;
        end
      end
      default: state_d = StHalt;
    endcase
  end

  always_comb begin
    retired_d = retired_q;
    if (clr_cnt) begin
      retired_d = 16'h0000;
    end else if (cpu_en) begin
      retired_d = retired_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StHalt;
      cause_q   <= CauseNone;
      skip_q    <= 1'b0;
      retired_q <= 16'h0000;
    end else begin
      state_q   <= state_d;
      cause_q   <= cause_d;
      skip_q    <= skip_d;
      retired_q <= retired_d;
    end
  end

  assign state      = state_q;
  assign stop_cause = cause_q;
  assign bp_hit     = (state_q == StBreak);
  assign retired    = retired_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl: a tiny core model (PC + IMEM) is driven by cpu_en.
module tb_cpu_run_ctrl;

  logic        clk;
  logic        reset;
  logic        run_btn, step_btn, halt_btn, clr_cnt, bp_en;
  logic [7:0]  bp_addr;
  logic [7:0]  pc;
  logic [7:0]  instruction;
  logic        cpu_en;
  logic [1:0]  state;
  logic [1:0]  stop_cause;
  logic        bp_hit;
  logic [15:0] retired;

  logic [7:0]  imem [256];
  logic        en_s;
  int          en_cnt;
  int          vectors;
  int          miscompares;

  cpu_run_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .run_btn     (run_btn),
    .step_btn    (step_btn),
    .halt_btn    (halt_btn),
    .clr_cnt     (clr_cnt),
    .bp_en       (bp_en),
    .bp_addr     (bp_addr),
    .pc          (pc),
    .instruction (instruction),
    .cpu_en      (cpu_en),
    .state       (state),
    .stop_cause  (stop_cause),
    .bp_hit      (bp_hit),
    .retired     (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign instruction = imem[pc];

  // cpu_en is captured mid-cycle so the core model sees the pre-edge value
  always @(negedge clk) begin
    en_s <= cpu_en;
    if (cpu_en && reset) en_cnt <= en_cnt + 1;
  end

  always @(posedge clk or negedge reset) begin
    if (!reset) pc <= 8'h00;
    else if (en_s) pc <= pc + 8'h01;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    reset = 1'b0;
    tick();
    tick();
    en_cnt = 0;
    reset = 1'b1;
    tick();
  endtask

  task automatic pulse_run;
    run_btn = 1'b1;
    tick();
    run_btn = 1'b0;
  endtask

  task automatic pulse_step;
    step_btn = 1'b1;
    tick();
    step_btn = 1'b0;
  endtask

  task automatic pulse_halt;
    halt_btn = 1'b1;
    tick();
    halt_btn = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    repeat (5) tick();
    @(negedge clk);
    vectors++;
    if (state !== 2'd0) begin
      $display("FAIL reset_state: got %0d want 0", state); miscompares++;
    end
    vectors++;
    if (cpu_en !== 1'b0) begin
      $display("FAIL reset_cpu_en: got %b want 0", cpu_en); miscompares++;
    end
    vectors++;
    if (retired !== 16'h0000) begin
      $display("FAIL reset_retired: got %h want 0000", retired); miscompares++;
    end
    vectors++;
    if (stop_cause !== 2'd0) begin
      $display("FAIL reset_cause: got %0d want 0", stop_cause); miscompares++;
    end
    vectors++;
    if (bp_hit !== 1'b0) begin
      $display("FAIL reset_bp_hit: got %b want 0", bp_hit); miscompares++;
    end
  endtask

  task automatic test_run_halt;
    apply_reset();
    pulse_run();
    repeat (10) tick();
    halt_btn = 1'b1;
    @(negedge clk);
    vectors++;
    if (cpu_en !== 1'b0) begin
      $display("FAIL run_halt_comb_drop: got %b want 0", cpu_en); miscompares++;
    end
    tick();
    halt_btn = 1'b0;
    @(negedge clk);
    vectors++;
    if (en_cnt !== 10) begin
      $display("FAIL run_halt_en_cycles: got %0d want 10", en_cnt); miscompares++;
    end
    vectors++;
    if (retired !== 16'd10) begin
      $display("FAIL run_halt_retired: got %0d want 10", retired); miscompares++;
    end
    vectors++;
    if (state !== 2'd0) begin
      $display("FAIL run_halt_state: got %0d want 0", state); miscompares++;
    end
    vectors++;
    if (stop_cause !== 2'd1) begin
      $display("FAIL run_halt_cause: got %0d want 1", stop_cause); miscompares++;
    end
    // halt_btn is ignored while halted
    pulse_halt();
    @(negedge clk);
    vectors++;
    if (state !== 2'd0 || pc !== 8'd10) begin
      $display("FAIL halt_in_halt: got state %0d pc %0d want 0 10", state, pc); miscompares++;
    end
  endtask

  task automatic test_step;
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      pulse_step();
      @(negedge clk);
      vectors++;
      if (cpu_en !== 1'b1 || state !== 2'd2) begin
        $display("FAIL step%0d_active: got en %b state %0d want 1 2", i, cpu_en, state);
        miscompares++;
      end
      tick();
      @(negedge clk);
      vectors++;
      if (cpu_en !== 1'b0 || state !== 2'd0) begin
        $display("FAIL step%0d_after: got en %b state %0d want 0 0", i, cpu_en, state);
        miscompares++;
      end
      vectors++;
      if (pc !== 8'(i + 1)) begin
        $display("FAIL step%0d_pc: got %0d want %0d", i, pc, i + 1); miscompares++;
      end
      tick();
      tick();
    end
    vectors++;
    if (retired !== 16'd3 || en_cnt !== 3) begin
      $display("FAIL step_retired: got %0d (%0d pulses) want 3", retired, en_cnt);
      miscompares++;
    end
  endtask

  task automatic test_breakpoint;
    apply_reset();
    bp_en   = 1'b1;
    bp_addr = 8'h05;
    pulse_run();
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (state == 2'd3) break;
    end
    vectors++;
    if (state !== 2'd3 || bp_hit !== 1'b1) begin
      $display("FAIL bp_stop_state: got %0d hit %b want 3 1", state, bp_hit); miscompares++;
    end
    vectors++;
    if (pc !== 8'h05 || stop_cause !== 2'd3 || retired !== 16'd5) begin
      $display("FAIL bp_stop_pc_cause_ret: got %0d %0d %0d want 5 3 5", pc, stop_cause, retired);
      miscompares++;
    end
    vectors++;
    if (cpu_en !== 1'b0) begin
      $display("FAIL bp_stop_en: got %b want 0", cpu_en); miscompares++;
    end
    tick();
    pulse_run();
    @(negedge clk);
    vectors++;
    if (cpu_en !== 1'b1 || state !== 2'd1) begin
      $display("FAIL bp_resume: got en %b state %0d want 1 1", cpu_en, state); miscompares++;
    end
    tick();
    @(negedge clk);
    vectors++;
    if (pc !== 8'h06 || state !== 2'd1 || cpu_en !== 1'b1) begin
      $display("FAIL bp_resume_cont: got pc %0d state %0d en %b want 6 1 1", pc, state, cpu_en);
      miscompares++;
    end
    pulse_halt();
    bp_en = 1'b0;
  endtask

  task automatic test_halt_inst;
    apply_reset();
    imem[3] = 8'hFF;
    pulse_run();
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (state == 2'd0) break;
    end
    vectors++;
    if (pc !== 8'd3 || stop_cause !== 2'd2 || retired !== 16'd3) begin
      $display("FAIL hinst_stop: got pc %0d cause %0d ret %0d want 3 2 3", pc, stop_cause,
               retired);
      miscompares++;
    end
    tick();
    pulse_step();
    @(negedge clk);
    vectors++;
    if (cpu_en !== 1'b0 || state !== 2'd2) begin
      $display("FAIL hinst_step_en: got en %b state %0d want 0 2", cpu_en, state); miscompares++;
    end
    tick();
    @(negedge clk);
    vectors++;
    if (pc !== 8'd3 || state !== 2'd0 || stop_cause !== 2'd2) begin
      $display("FAIL hinst_step_after: got pc %0d state %0d cause %0d want 3 0 2", pc, state,
               stop_cause);
      miscompares++;
    end
    imem[3] = 8'h00;
  endtask

  task automatic test_wrap_clear;
    apply_reset();
    pulse_run();
    repeat (65535) tick();
    pulse_halt();
    @(negedge clk);
    vectors++;
    if (retired !== 16'hFFFF) begin
      $display("FAIL wrap_preload: got %h want ffff", retired); miscompares++;
    end
    pulse_step();
    tick();
    @(negedge clk);
    vectors++;
    if (retired !== 16'h0000) begin
      $display("FAIL wrap_step: got %h want 0000", retired); miscompares++;
    end
    pulse_step();
    tick();
    @(negedge clk);
    vectors++;
    if (retired !== 16'h0001) begin
      $display("FAIL clr_pre: got %h want 0001", retired); miscompares++;
    end
    // clear lands on the same edge as the step's enabled cycle
    step_btn = 1'b1;
    tick();
    step_btn = 1'b0;
    clr_cnt  = 1'b1;
    @(negedge clk);
    vectors++;
    if (cpu_en !== 1'b1) begin
      $display("FAIL clr_en_cycle: got %b want 1", cpu_en); miscompares++;
    end
    tick();
    clr_cnt = 1'b0;
    @(negedge clk);
    vectors++;
    if (retired !== 16'h0000) begin
      $display("FAIL clr_vs_inc: got %h want 0000", retired); miscompares++;
    end
  endtask

  task automatic test_back_to_back;
    apply_reset();
    run_btn  = 1'b1;
    step_btn = 1'b1;
    tick();
    run_btn  = 1'b0;
    step_btn = 1'b0;
    @(negedge clk);
    vectors++;
    if (state !== 2'd2) begin
      $display("FAIL step_beats_run: got %0d want 2", state); miscompares++;
    end
    tick();
    pulse_run();
    pulse_halt();
    pulse_run();
    repeat (3) tick();
    #2;
    reset = 1'b0;
    #1;
    vectors++;
    if (cpu_en !== 1'b0 || state !== 2'd0 || bp_hit !== 1'b0) begin
      $display("FAIL midrun_reset_ctl: got en %b state %0d hit %b want 0 0 0", cpu_en, state,
               bp_hit);
      miscompares++;
    end
    vectors++;
    if (stop_cause !== 2'd0 || retired !== 16'h0000) begin
      $display("FAIL midrun_reset_regs: got cause %0d ret %h want 0 0000", stop_cause, retired);
      miscompares++;
    end
    tick();
    tick();
    vectors++;
    if (retired !== 16'h0000 || pc !== 8'h00) begin
      $display("FAIL midrun_reset_hold: got ret %h pc %0d want 0000 0", retired, pc);
      miscompares++;
    end
    reset = 1'b1;
    tick();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    en_cnt      = 0;
    en_s        = 1'b0;
    reset       = 1'b0;
    run_btn     = 1'b0;
    step_btn    = 1'b0;
    halt_btn    = 1'b0;
    clr_cnt     = 1'b0;
    bp_en       = 1'b0;
    bp_addr     = 8'h00;
    for (int i = 0; i < 256; i++) imem[i] = 8'h00;
    test_reset();
    test_run_halt();
    test_step();
    test_breakpoint();
    test_halt_inst();
    test_wrap_clear();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
